// File: rtl/avr_uart_pkg.sv
// avr_uart_pkg: shared constants and helpers for the AVR-side UART blocks
// Contents: receiver state encoding, parity mode constants, baud divisor function.
package avr_uart_pkg;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int uart_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/avr_uart_sync.sv
// avr_uart_sync: 2-flop synchronizer for a serial line, x/z read as idle 1
// Ports: clk core clock; rst_n async active-low reset (flops reset to 1);
//        i_d raw line; o_q synchronized line, 2 clk latency.
module avr_uart_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_sync;
    logic       w_d;

    // Only a solid 0 counts as low; a floating or unknown pin is the pull-up idle level.
    assign w_d = (i_d !== 1'b0);
    assign o_q = r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], w_d};
    end
endmodule

// File: rtl/avr_uart_rx.sv
// avr_uart_rx: asynchronous serial receiver for the simulated AVR TXD pin
// Ports: clk core clock; rst_n async active-low reset; rxd serial line (x/z = idle);
//        data/valid/ready one-entry holding register with handshake;
//        frame_err/parity_err flags of the held byte; overrun sticky lost-frame flag;
//        busy receiver is inside a frame.
module avr_uart_rx
    import avr_uart_pkg::*;
#(
    parameter int CLK_FREQ  = 4_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV = uart_div(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(DIV) + 1;

    generate
        if (DIV < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
            $error("avr_uart_rx: illegal parameter set");
        end
    endgenerate

    logic                 w_rxs, w_tick, w_commit, w_drain, w_ferr;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift, r_data;
    logic                 r_prev, r_par, r_perr_acc, r_ferr_acc, r_stop2;
    logic                 r_valid, r_ferr, r_perr, r_ovr;

    avr_uart_sync u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  (rxd),
        .o_q  (w_rxs)
    );

    assign w_tick   = (r_cnt == '0);
    // The last stop sample is the commit point; with two stop bits that is the second one.
    assign w_commit = (r_state == ST_STOP) && w_tick && (STOP_BITS == 1 || r_stop2);
    assign w_drain  = r_valid && ready;
    assign w_ferr   = r_ferr_acc | ~w_rxs;

    assign data       = r_data;
    assign valid      = r_valid;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign overrun    = r_ovr;
    assign busy       = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_prev     <= 1'b1;
            r_par      <= 1'b0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_stop2    <= 1'b0;
        end else begin
            // r_prev tracks rxs in every state, so after a break the line must
            // return high before another falling edge can arm IDLE.
            r_prev <= w_rxs;
            if (r_state != ST_IDLE && !w_tick) r_cnt <= r_cnt - 1'b1;
            case (r_state)
                ST_IDLE: if (r_prev && !w_rxs) begin
                    r_cnt   <= CW'(DIV / 2 - 1);
                    r_state <= ST_START;
                end
                ST_START: if (w_tick) begin
                    if (w_rxs) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt      <= CW'(DIV - 1);
                        r_bit      <= '0;
                        r_par      <= 1'b0;
                        r_perr_acc <= 1'b0;
                        r_ferr_acc <= 1'b0;
                        r_stop2    <= 1'b0;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: if (w_tick) begin
                    r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                    r_par   <= r_par ^ w_rxs;
                    r_bit   <= r_bit + 1'b1;
                    r_cnt   <= CW'(DIV - 1);
                    if (r_bit == 4'(DATA_BITS - 1))
                        r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: if (w_tick) begin
                    r_perr_acc <= (PARITY == PAR_ODD) ? ~(r_par ^ w_rxs) : (r_par ^ w_rxs);
                    r_cnt      <= CW'(DIV - 1);
                    r_state    <= ST_STOP;
                end
                ST_STOP: if (w_tick) begin
                    if (w_commit) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ferr_acc <= ~w_rxs;
                        r_stop2    <= 1'b1;
                        r_cnt      <= CW'(DIV - 1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            // A drain on the commit edge frees the slot, so the new frame still lands.
            if (w_commit && (!r_valid || ready)) begin
                r_data  <= r_shift;
                r_ferr  <= w_ferr;
                r_perr  <= r_perr_acc;
                r_valid <= 1'b1;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
            r_ovr <= (w_commit && r_valid && !ready) ? 1'b1 : (w_drain ? 1'b0 : r_ovr);
        end
    end
endmodule

// File: tb/tb_avr_uart_rx.sv
// tb_avr_uart_rx: self-checking bench for avr_uart_rx at DIV=16
// Units: u0 8N1 on a pulled-up line, u1 8E1, u2 8O2.
module tb_avr_uart_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic drv_en = 1'b1, drv0 = 1'b1, rxd1 = 1'b1, rxd2 = 1'b1;
    logic ready0 = 1'b1, ready1 = 1'b1, ready2 = 1'b1;
    wire  rxd0;
    logic [7:0] d0, d1, d2;
    logic v0, v1, v2, fe0, fe1, fe2, pe0, pe1, pe2, ov0, ov1, ov2, bz0, bz1, bz2;
    logic [9:0] q0[$], q1[$], q2[$], qe[$];
    int total = 0, bad = 0;

    pullup (rxd0);
    assign rxd0 = drv_en ? drv0 : 1'bz;

    always #5 clk = ~clk;

    avr_uart_rx #(.CLK_FREQ(4_000_000), .BAUD(250_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd0), .data(d0), .valid(v0), .ready(ready0),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(bz0));
    avr_uart_rx #(.CLK_FREQ(4_000_000), .BAUD(250_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd1), .data(d1), .valid(v1), .ready(ready1),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(bz1));
    avr_uart_rx #(.CLK_FREQ(4_000_000), .BAUD(250_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd2), .data(d2), .valid(v2), .ready(ready2),
        .frame_err(fe2), .parity_err(pe2), .overrun(ov2), .busy(bz2));

    // Every accepted transfer is logged as {frame_err, parity_err, data}.
    always @(negedge clk) begin
        if (v0 && ready0) q0.push_back({fe0, pe0, d0});
        if (v1 && ready1) q1.push_back({fe1, pe1, d1});
        if (v2 && ready2) q2.push_back({fe2, pe2, d2});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input int u, input string name, input logic [7:0] ed,
                           input logic epe, input logic efe);
        logic [9:0] e;
        int sz;
        sz = (u == 0) ? q0.size() : (u == 1) ? q1.size() : q2.size();
        chk({name, " present"}, 32'(sz != 0), 1);
        if (sz == 0) return;
        case (u)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        chk({name, " data"}, e[7:0], ed);
        chk({name, " perr"}, e[8], epe);
        chk({name, " ferr"}, e[9], efe);
    endtask

    task automatic set_line(input int u, input logic v);
        case (u)
            0: drv0 = v;
            1: rxd1 = v;
            default: rxd2 = v;
        endcase
    endtask

    task automatic bit_time(input int u, input logic v);
        set_line(u, v);
        repeat (16) @(posedge clk);
        #1;
    endtask

    // One frame as the AVR would send it; flip inverts the correct parity bit.
    task automatic tx(input int u, input logic [7:0] d, input logic flip, input logic s1, input logic s2);
        bit_time(u, 1'b0);
        for (int i = 0; i < 8; i++) bit_time(u, d[i]);
        if (u != 0) bit_time(u, (^d) ^ (u == 2) ^ flip);
        bit_time(u, s1);
        if (u == 2) bit_time(u, s2);
        set_line(u, 1'b1);
    endtask

    typedef struct {
        int         u;
        logic [7:0] d;
        logic       flip;
        logic       s1;
        logic       s2;
        logic [7:0] ed;
        logic       epe;
        logic       efe;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int n, g;
        logic [7:0] b;
        logic f;
        tbl[0] = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
        tbl[1] = '{1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        tbl[2] = '{1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1};
        tbl[5] = '{1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1};
        tbl[6] = '{2, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        tbl[7] = '{2, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
        tbl[8] = '{2, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1};
        tbl[9] = '{2, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1};

        repeat (4) @(posedge clk);
        #1;
        chk("reset data", d0, 8'h00);
        chk("reset valid", v0, 0);
        chk("reset ferr", fe0, 0);
        chk("reset perr", pe0, 0);
        chk("reset overrun", ov0, 0);
        chk("reset busy", bz0, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 0x55 8N1: latency from start edge and one-cycle valid pulse
        n = 0;
        fork
            tx(0, 8'h55, 1'b0, 1'b1, 1'b1);
            begin
                while (!v0 && n < 400) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                @(posedge clk);
                #1;
                chk("valid one-cycle pulse", v0, 0);
            end
        join
        total++;
        if (n < 154 || n > 156) begin
            bad++;
            $display("FAIL latency: got %0d clk want 155+-1", n);
        end
        pop_chk(0, "byte 55", 8'h55, 1'b0, 1'b0);
        chk("55 overrun", ov0, 0);

        // 4-clk glitch: false start returns to IDLE without a byte
        set_line(0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        set_line(0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("glitch busy during start", bz0, 1);
        repeat (14) @(posedge clk);
        #1;
        chk("glitch busy after start sample", bz0, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("glitch valid", v0, 0);
        chk("glitch no byte", q0.size(), 0);

        // back-to-back frames with consumer stalled: second one overruns
        ready0 = 1'b0;
        tx(0, 8'hA3, 1'b0, 1'b1, 1'b1);
        tx(0, 8'h3C, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("ovr valid held", v0, 1);
        chk("ovr data held", d0, 8'hA3);
        chk("ovr flag set", ov0, 1);
        ready0 = 1'b1;
        @(posedge clk);
        #1;
        ready0 = 1'b0;
        chk("ovr valid after drain", v0, 0);
        chk("ovr flag after drain", ov0, 0);
        chk("ovr data after drain", d0, 8'hA3);
        pop_chk(0, "ovr transfer", 8'hA3, 1'b0, 1'b0);
        ready0 = 1'b1;

        // break: line low for start + 8 data + 3 bit times
        set_line(0, 1'b0);
        repeat (12 * 16) @(posedge clk);
        #1;
        set_line(0, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        tx(0, 8'h81, 1'b0, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        pop_chk(0, "break byte", 8'h00, 1'b0, 1'b1);
        pop_chk(0, "after break", 8'h81, 1'b0, 1'b0);
        chk("break extra bytes", q0.size(), 0);

        // parity / stop-bit vector table on u1 (even) and u2 (odd, 2 stop)
        for (int i = 0; i < 10; i++) begin
            tx(tbl[i].u, tbl[i].d, tbl[i].flip, tbl[i].s1, tbl[i].s2);
            repeat (5) @(posedge clk);
            #1;
            pop_chk(tbl[i].u, $sformatf("vec%0d", i), tbl[i].ed, tbl[i].epe, tbl[i].efe);
        end
        chk("vec u1 extra", q1.size(), 0);
        chk("vec u2 extra", q2.size(), 0);

        // random bytes with random gaps (0 = back-to-back) on u0
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            qe.push_back({2'b00, b});
            g = $urandom_range(0, 12);
            if (g != 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            tx(0, b, 1'b0, 1'b1, 1'b1);
        end
        repeat (30) @(posedge clk);
        #1;
        chk("rand u0 count", q0.size(), qe.size());
        for (int i = 0; i < 16 && qe.size() != 0; i++) begin
            b = qe[0][7:0];
            void'(qe.pop_front());
            pop_chk(0, $sformatf("rand0[%0d]", i), b, 1'b0, 1'b0);
        end
        qe.delete();

        // random bytes with random parity corruption on u1
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            f = 1'($urandom_range(0, 1));
            qe.push_back({1'b0, f, b});
            tx(1, b, f, 1'b1, 1'b1);
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
        end
        repeat (30) @(posedge clk);
        #1;
        chk("rand u1 count", q1.size(), qe.size());
        for (int i = 0; i < 12 && qe.size() != 0; i++) begin
            b = qe[0][7:0];
            f = qe[0][8];
            void'(qe.pop_front());
            pop_chk(1, $sformatf("rand1[%0d]", i), b, f, 1'b0);
        end

        // floating line, then a byte, then reset in the middle of a second frame
        ready0 = 1'b0;
        drv_en = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("z busy", bz0, 0);
        chk("z valid", v0, 0);
        drv0 = 1'b1;
        drv_en = 1'b1;
        tx(0, 8'h12, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("after z valid", v0, 1);
        chk("after z data", d0, 8'h12);
        bit_time(0, 1'b0);
        bit_time(0, 1'b0);
        bit_time(0, 1'b1);
        bit_time(0, 1'b0);
        chk("mid-frame busy", bz0, 1);
        rst_n = 1'b0;
        #1;
        chk("mid reset valid", v0, 0);
        chk("mid reset data", d0, 8'h00);
        chk("mid reset busy", bz0, 0);
        chk("mid reset overrun", ov0, 0);
        chk("mid reset ferr", fe0, 0);
        set_line(0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("aborted frame valid", v0, 0);
        chk("aborted frame busy", bz0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
